// File: rtl/zpulse_count_capture_ram.sv
// Gated photon-pulse counter: one saturating count per window into block RAM, read via req/done.
// Define ZPD_PINGPONG_EN for two RAM banks so readers only ever see the last completed capture.
module zpulse_count_capture_ram #(
    parameter int WINDOW_CYCLES = 16667,
    parameter int DEPTH         = 3000,
    parameter int AW            = 12,
    parameter int DW            = 16
) (
    input  logic          iClk,
    input  logic          iRst_N,
    input  logic          iPulse,
    input  logic          iStart,
    output logic          oCaptureBusy,
    output logic          oCaptureDone,
    input  logic          iBlockRAM_RdReq,
    input  logic [AW-1:0] iBlockRAM_RdReq_Addr,
    output logic [DW-1:0] oBlockRAM_RdData,
    output logic          oBlockRAM_RdDone
);

    localparam int WCW = $clog2(WINDOW_CYCLES);
`ifdef ZPD_PINGPONG_EN
    localparam int NWORDS = 2 * DEPTH;
    localparam int MAW    = AW + 1;
`else
    localparam int NWORDS = DEPTH;
    localparam int MAW    = AW;
`endif

    typedef enum logic [1:0] {C_IDLE, C_RUN, C_DONE} cstate_t;
    typedef enum logic [1:0] {R_IDLE, R_RD, R_ACK, R_WAIT} rstate_t;

    cstate_t r_cstate, w_cstate_nxt;
    rstate_t r_rstate, w_rstate_nxt;

    logic [2:0]     r_sync;
    logic [WCW-1:0] r_win_cnt;
    logic [AW-1:0]  r_wr_addr;
    logic [DW-1:0]  r_count;
    logic [DW-1:0]  r_ram_q;
    logic [DW-1:0]  r_rd_data;
    logic           r_rd_oob;
    logic [DW-1:0]  r_mem [NWORDS];

    logic           w_edge;
    logic           w_start;
    logic           w_win_end;
    logic           w_last;
    logic           w_wr_en;
    logic           w_rd_acc;
    logic           w_rd_en;
    logic           w_rd_oob_in;
    logic [DW-1:0]  w_count_inc;
    logic [MAW-1:0] w_wr_idx;
    logic [MAW-1:0] w_rd_idx;

    assign w_edge      = r_sync[1] & ~r_sync[2];
    assign w_count_inc = (w_edge && r_count != {DW{1'b1}}) ? r_count + 1'b1 : r_count;
    assign w_win_end   = (r_win_cnt == WCW'(WINDOW_CYCLES - 1));
    assign w_last      = (r_wr_addr == AW'(DEPTH - 1));
    assign w_rd_oob_in = ({1'b0, iBlockRAM_RdReq_Addr} >= (AW + 1)'(DEPTH));
    assign w_rd_en     = w_rd_acc & ~w_rd_oob_in;

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            r_cstate <= C_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_cstate <= w_cstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_cstate_nxt = r_cstate;
        w_start      = 1'b0;
        w_wr_en      = 1'b0;
        oCaptureBusy = 1'b0;
        oCaptureDone = 1'b0;
        unique case (r_cstate)
            C_IDLE: begin
                if (iStart) begin
                    w_start      = 1'b1;
                    w_cstate_nxt = C_RUN;
                end
            end
            C_RUN: begin
                oCaptureBusy = 1'b1;
                if (w_win_end) begin
                    w_wr_en = 1'b1;
                    if (w_last) w_cstate_nxt = C_DONE;
                end
            end
            C_DONE: begin
                oCaptureDone = 1'b1;
                w_cstate_nxt = C_IDLE;
            end
            default: w_cstate_nxt = C_IDLE;
        endcase
    end

    // The closing window's own edge goes through w_count_inc into RAM, so none is lost.
    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            r_sync    <= '0;
            r_win_cnt <= '0;
            r_wr_addr <= '0;
            r_count   <= '0;
        end else begin
            r_sync <= {r_sync[1:0], iPulse};
            if (w_start) begin
                r_win_cnt <= '0;
                r_wr_addr <= '0;
                r_count   <= '0;
            end else if (oCaptureBusy) begin
                if (w_win_end) begin
                    r_win_cnt <= '0;
                    r_count   <= '0;
                    if (!w_last) r_wr_addr <= r_wr_addr + 1'b1;
                end else begin
                    r_win_cnt <= r_win_cnt + 1'b1;
                    r_count   <= w_count_inc;
                end
            end
        end
    end

`ifdef ZPD_PINGPONG_EN
    logic r_wr_bank;
    logic r_rd_bank;

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else if (w_wr_en && w_last) begin
            r_rd_bank <= r_wr_bank;
            r_wr_bank <= ~r_wr_bank;
        end
    end

    assign w_wr_idx = MAW'(r_wr_addr) + (r_wr_bank ? MAW'(DEPTH) : '0);
    assign w_rd_idx = MAW'(iBlockRAM_RdReq_Addr) + (r_rd_bank ? MAW'(DEPTH) : '0);
`else
    assign w_wr_idx = r_wr_addr;
    assign w_rd_idx = iBlockRAM_RdReq_Addr;
`endif

    // Non-blocking read and write on one edge give read-first collision behaviour.
    always_ff @(posedge iClk) begin
        if (w_wr_en) r_mem[w_wr_idx] <= w_count_inc;
        if (w_rd_en) r_ram_q <= r_mem[w_rd_idx];
    end

    always_comb begin
        w_rstate_nxt     = r_rstate;
        w_rd_acc         = 1'b0;
        oBlockRAM_RdDone = 1'b0;
        unique case (r_rstate)
            R_IDLE: begin
                if (iBlockRAM_RdReq) begin
                    w_rd_acc     = 1'b1;
                    w_rstate_nxt = R_RD;
                end
            end
            R_RD:   w_rstate_nxt = R_ACK;
            R_ACK: begin
                oBlockRAM_RdDone = 1'b1;
                w_rstate_nxt     = R_WAIT;
            end
            R_WAIT: begin
                if (!iBlockRAM_RdReq) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            r_rd_oob  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (w_rd_acc) r_rd_oob <= w_rd_oob_in;
            if (r_rstate == R_RD) r_rd_data <= r_rd_oob ? '0 : r_ram_q;
        end
    end

    assign oBlockRAM_RdData = r_rd_data;

endmodule

// File: tb/tb_zpulse_count_capture_ram.sv
// Directed bench for zpulse_count_capture_ram: window counts, readback handshake,
// out-of-range reads, saturation (narrow second instance) and reset abort.
module tb_zpulse_count_capture_ram;

    localparam int W  = 20;
    localparam int D  = 4;
    localparam int AW = 3;
    localparam int DW = 16;
    localparam int NC = 4 * W;

    logic          iClk    = 1'b0;
    logic          iRst_N  = 1'b0;
    logic          iPulse  = 1'b0;
    logic          iStart  = 1'b0;
    logic          iRdReq  = 1'b0;
    logic [AW-1:0] iRdAddr = '0;
    logic          oBusy;
    logic          oDone;
    logic          oRdDone;
    logic [DW-1:0] oRdData;

    logic          sPulse  = 1'b0;
    logic          sStart  = 1'b0;
    logic          sRdReq  = 1'b0;
    logic [0:0]    sRdAddr = '0;
    logic          sBusy;
    logic          sDone;
    logic          sRdDone;
    logic [3:0]    sRdData;

    int n_vec = 0;
    int n_bad = 0;

    always #5 iClk = ~iClk;

    zpulse_count_capture_ram #(
        .WINDOW_CYCLES(W), .DEPTH(D), .AW(AW), .DW(DW)
    ) u_dut (
        .iClk                 (iClk),
        .iRst_N               (iRst_N),
        .iPulse               (iPulse),
        .iStart               (iStart),
        .oCaptureBusy         (oBusy),
        .oCaptureDone         (oDone),
        .iBlockRAM_RdReq      (iRdReq),
        .iBlockRAM_RdReq_Addr (iRdAddr),
        .oBlockRAM_RdData     (oRdData),
        .oBlockRAM_RdDone     (oRdDone)
    );

    zpulse_count_capture_ram #(
        .WINDOW_CYCLES(40), .DEPTH(1), .AW(1), .DW(4)
    ) u_sat (
        .iClk                 (iClk),
        .iRst_N               (iRst_N),
        .iPulse               (sPulse),
        .iStart               (sStart),
        .oCaptureBusy         (sBusy),
        .oCaptureDone         (sDone),
        .iBlockRAM_RdReq      (sRdReq),
        .iBlockRAM_RdReq_Addr (sRdAddr),
        .oBlockRAM_RdData     (sRdData),
        .oBlockRAM_RdDone     (sRdDone)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Pulse level per cycle; n[w] edges start 2 cycles into window w, one every 2 cycles.
    function automatic logic [NC-1:0] make_pat(input int n0, input int n1,
                                                input int n2, input int n3);
        int            n [4];
        logic [NC-1:0] p;
        n = '{n0, n1, n2, n3};
        p = '0;
        for (int w = 0; w < 4; w++)
            for (int i = 0; i < n[w]; i++)
                p[w * W + 2 + 2 * i] = 1'b1;
        return p;
    endfunction

    task automatic run_capture(input logic [NC-1:0] pat, input int abort_at,
                               output int lat, output int ndone);
        lat    = 0;
        ndone  = 0;
        iStart = 1'b1;
        for (int m = 0; m < NC + 6; m++) begin
            @(posedge iClk);
            #1;
            iStart = 1'b0;
            if (oDone) begin
                ndone++;
                if (lat == 0) lat = m + 1;
            end
            @(negedge iClk);
            iPulse = (m < NC) ? pat[m] : 1'b0;
            if (m == abort_at) begin
                iRst_N = 1'b0;
                #1;
                chk("rst_busy_async", 32'(oBusy), 32'd0);
            end
            if (m == abort_at + 3) iRst_N = 1'b1;
        end
        iPulse = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input int hold,
                      output logic [DW-1:0] d, output int lat, output int ndone);
        lat     = 0;
        ndone   = 0;
        d       = 'x;
        iRdReq  = 1'b1;
        iRdAddr = a;
        for (int n = 1; n <= hold; n++) begin
            @(posedge iClk);
            #1;
            if (oRdDone) begin
                ndone++;
                if (lat == 0) begin
                    lat = n;
                    d   = oRdData;
                end
            end
            @(negedge iClk);
        end
        iRdReq = 1'b0;
        repeat (2) @(negedge iClk);
    endtask

    task automatic expect_word(input string tag, input logic [AW-1:0] a,
                               input logic [DW-1:0] exp);
        logic [DW-1:0] d;
        int            lat;
        int            nd;
        rd(a, 4, d, lat, nd);
        chk(tag, 32'(d), 32'(exp));
    endtask

    task automatic rd_sat(input logic [0:0] a, output logic [3:0] d);
        d       = 'x;
        sRdReq  = 1'b1;
        sRdAddr = a;
        for (int n = 0; n < 6; n++) begin
            @(posedge iClk);
            #1;
            if (sRdDone) d = sRdData;
            @(negedge iClk);
        end
        sRdReq = 1'b0;
        repeat (2) @(negedge iClk);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [NC-1:0] p;
        logic [3:0]    d4;
        int            lat;
        int            nd;

        repeat (3) @(negedge iClk);
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_done", 32'(oDone), 32'd0);
        chk("rst_rddone", 32'(oRdDone), 32'd0);
        chk("rst_rddata", 32'(oRdData), 32'd0);
        iRst_N = 1'b1;
        repeat (2) @(negedge iClk);

        run_capture(make_pat(3, 0, 7, 1), -10, lat, nd);
        chk("cap1_done_lat", lat, 81);
        chk("cap1_done_cnt", nd, 1);
        chk("cap1_busy_after", 32'(oBusy), 32'd0);
        expect_word("cap1_w0", 3'd0, 16'd3);
        expect_word("cap1_w1", 3'd1, 16'd0);
        expect_word("cap1_w2", 3'd2, 16'd7);
        expect_word("cap1_w3", 3'd3, 16'd1);

        rd(3'd2, 20, d, lat, nd);
        chk("hold_done_cnt", nd, 1);
        chk("hold_done_lat", lat, 2);
        chk("hold_data", 32'(d), 32'd7);
        chk("hold_data_kept", 32'(oRdData), 32'd7);
        rd(3'd5, 4, d, lat, nd);
        chk("oob_data", 32'(d), 32'd0);
        chk("oob_done_lat", lat, 2);

        p     = '0;
        p[17] = 1'b1;
        run_capture(p, -10, lat, nd);
        chk("edge_last_done", nd, 1);
        expect_word("edge_last_w0", 3'd0, 16'd1);
        expect_word("edge_last_w1", 3'd1, 16'd0);

        run_capture(make_pat(2, 5, 3, 0), 50, lat, nd);
        chk("abort_no_done", nd, 0);
        chk("abort_busy", 32'(oBusy), 32'd0);
        expect_word("abort_w0", 3'd0, 16'd2);
        expect_word("abort_w1", 3'd1, 16'd5);
        run_capture(make_pat(4, 1, 0, 0), -10, lat, nd);
        chk("restart_done_lat", lat, 81);
        expect_word("restart_w0", 3'd0, 16'd4);
        expect_word("restart_w1", 3'd1, 16'd1);

        sStart = 1'b1;
        @(negedge iClk);
        sStart = 1'b0;
        for (int m = 0; m < 40; m++) begin
            sPulse = (m >= 2 && m <= 36 && m % 2 == 0);
            @(negedge iClk);
        end
        chk("sat_done", 32'(sDone), 32'd1);
        rd_sat(1'b0, d4);
        chk("sat_data", 32'(d4), 32'hF);
        rd_sat(1'b1, d4);
        chk("sat_oob", 32'(d4), 32'd0);

`ifdef ZPD_PINGPONG_EN
        begin
            int lat_b;
            int nd_b;
            run_capture(make_pat(1, 2, 3, 4), -10, lat, nd);
            chk("pp_a_done", nd, 1);
            fork
                run_capture(make_pat(5, 0, 1, 2), -10, lat_b, nd_b);
                begin
                    repeat (70) @(negedge iClk);
                    rd(3'd2, 4, d, lat, nd);
                end
            join
            chk("pp_read_during_b", 32'(d), 32'd3);
            chk("pp_b_done", nd_b, 1);
            expect_word("pp_after_b_w0", 3'd0, 16'd5);
            expect_word("pp_after_b_w2", 3'd2, 16'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
